led_prog_ram: RTL and testbench
===============================

Name: led_prog_ram

Overview:
- Program memory plus byte-serial loader feeding the LED CPU core.
- Core side: synchronous read port; the core drives addrRd and samples dataRd.
- Host side: a byte stream (switch/UART front end) is assembled into 16-bit instruction words and written sequentially from address 0.
- While a load is in progress, the block asserts loading, which the top level ORs into the core's reset.

Parameters:
- ADDR_W, 8, address width; memory depth DEPTH = 2**ADDR_W words.
- DATA_W, 16, word width; fixed at 16 (two bytes per word).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- addrRd  input  ADDR_W  core read address.
- dataRd  output  DATA_W  registered read data, mem[addrRd] from previous cycle.
- load_start  input  1  single-cycle pulse; begins (or restarts) a load.
- load_end  input  1  single-cycle pulse; terminates the load.
- byte_in  input  8  loader byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader can accept a byte this cycle.
- loading  output  1  load in progress.
- words_loaded  output  ADDR_W+1  words written in the current/last load.
- overflow  output  1  sticky: bytes arrived after memory was full.

Behaviour:
- Reset (rst=0, async): FSM=IDLE; dataRd=0; byte_ready=0; loading=0; words_loaded=0; overflow=0; write pointer=0. Memory contents are not cleared.
- Read port:
  - dataRd <= mem[addrRd] on every clock edge, in all states; latency 1 cycle.
  - Read and write to the same address in the same cycle returns the old data.
- Byte accept: a byte transfers when byte_valid && byte_ready on a clock edge.
- FSM state IDLE:
  - byte_ready=0, loading=0.
  - load_start -> HI; ptr=0; words_loaded=0; overflow=0.
- FSM state HI:
  - byte_ready=1, loading=1.
  - Accepted byte is latched as the high byte -> LO.
  - load_end with no byte accepted -> IDLE.
- FSM state LO:
  - byte_ready=1, loading=1.
  - Accepted byte is the low byte -> WR.
  - load_end -> IDLE; the pending high byte is discarded; no write.
- FSM state WR (one cycle):
  - byte_ready=0, loading=1.
  - If words_loaded < DEPTH: mem[ptr] <= {hi,lo}; ptr <= ptr+1 (wraps to 0 only after the final word); words_loaded += 1.
  - Else: no write; overflow <= 1.
  - Then -> HI.
  - load_end during WR is registered and honoured on entry to HI (-> IDLE next cycle).
- load_start in HI/LO/WR restarts: ptr=0, words_loaded=0, overflow=0, partial byte discarded, -> HI. A write in progress in WR still completes.
- Simultaneous load_start and load_end: load_start wins.
- Throughput: max one word per 3 cycles (HI, LO, WR).
- words_loaded saturates at DEPTH. overflow stays set until the next load_start or reset.
- Reset mid-load: immediate return to IDLE. Words already written stay in memory.

Test Plan:
- Reset then read: rst low 3 cycles, release; addrRd=0x05 -> dataRd=0x0000 until first edge after release, then mem[5] one cycle after each address change; loading=0, byte_ready=0.
- Basic load:
  - Stimulus: load_start; bytes 0xAA,0x03,0x55,0x03,0x00,0x00; load_end.
  - Response: mem[0]=0xAA03, mem[1]=0x5503, mem[2]=0x0000; words_loaded=3; loading high from the cycle after load_start until the cycle after load_end.
- Readback latency: after the load, addrRd=1 at cycle N -> dataRd=0x5503 at cycle N+1; addrRd=2 at N+1 -> 0x0000 at N+2.
- Partial word:
  - Stimulus: load_start; bytes 0x12,0x34,0x56; load_end while in LO.
  - Response: mem[0]=0x1234, mem[1] unchanged; words_loaded=1.
- Overflow: load 256 words then 2 more bytes -> words_loaded=256, overflow=1, mem[0] not overwritten; next load_start clears overflow and words_loaded.
- Restart and async reset:
  - load_start mid-word (state LO) -> pending byte dropped, next two bytes written to mem[0].
  - rst asserted mid-load between clock edges -> outputs zero immediately, loading=0 without a clock edge.

Source files
------------

// File: rtl/led_prog_ram.sv
// Program memory for the LED CPU core with a byte-serial loader.
// The core reads through a registered synchronous port. A host byte stream
// is packed high-byte-first into 16-bit words, which are written one after
// another starting at address 0. The loading output is ORed into the core
// reset at the top level, so the core stays in reset while a load runs.
module led_prog_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addrRd,
  output logic [DATA_W-1:0] dataRd,
  input  logic              load_start,
  input  logic              load_end,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              loading,
  output logic [ADDR_W:0]   words_loaded,
  output logic              overflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  // The word count equals DEPTH exactly when only its MSB is set.
  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HI   = 2'd1;
  localparam logic [1:0] ST_LO   = 2'd2;
  localparam logic [1:0] ST_WR   = 2'd3;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state_r, state_s;
  logic [ADDR_W-1:0] ptr_r, ptr_s;
  logic [ADDR_W:0]   words_r, words_s;
  logic              ovf_r, ovf_s;
  logic [7:0]        hi_r, hi_s;
  logic [7:0]        lo_r, lo_s;
  logic              end_pend_r, end_pend_s;
  logic              ready_r, ready_s;
  logic              loading_r, loading_s;
  logic              dout_we_s;
  logic              accept_s;
  logic [DATA_W-1:0] data_rd_r;

  assign dataRd       = data_rd_r;
  assign byte_ready   = ready_r;
  assign loading      = loading_r;
  assign words_loaded = words_r;
  assign overflow     = ovf_r;

  // Loader next-state logic: byte packing, word commit and load restart.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    words_s    = words_r;
    ovf_s      = ovf_r;
    hi_s       = hi_r;
    lo_s       = lo_r;
    end_pend_s = end_pend_r;
    dout_we_s  = 1'b0;
    accept_s   = byte_valid && ready_r;

    case (state_r)
      ST_IDLE: begin
        if (load_start) begin
          state_s    = ST_HI;
          ptr_s      = {ADDR_W{1'b0}};
          words_s    = {(ADDR_W+1){1'b0}};
          ovf_s      = 1'b0;
          end_pend_s = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HI: begin
        end_pend_s = 1'b0;
        if (load_start) begin
          state_s = ST_HI;
          ptr_s   = {ADDR_W{1'b0}};
          words_s = {(ADDR_W+1){1'b0}};
          ovf_s   = 1'b0;
        end else if (load_end || end_pend_r) begin
          // A load_end seen during WR ends the load here.
          state_s = ST_IDLE;
        end else if (accept_s) begin
          hi_s    = byte_in;
          state_s = ST_LO;
        end else begin
          state_s = ST_HI;
        end
      end
      ST_LO: begin
        end_pend_s = 1'b0;
        if (load_start) begin
          // The pending high byte is dropped; packing restarts at address 0.
          state_s = ST_HI;
          ptr_s   = {ADDR_W{1'b0}};
          words_s = {(ADDR_W+1){1'b0}};
          ovf_s   = 1'b0;
        end else if (load_end) begin
          state_s = ST_IDLE;
        end else if (accept_s) begin
          lo_s    = byte_in;
          state_s = ST_WR;
        end else begin
          state_s = ST_LO;
        end
      end
      ST_WR: begin
        if (words_r != DEPTH_C) begin
          dout_we_s = 1'b1;
          ptr_s     = ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          words_s   = words_r + {{ADDR_W{1'b0}}, 1'b1};
        end else begin
          ovf_s = 1'b1;
        end
        if (load_start) begin
          // The word being committed still lands; only the counters restart.
          ptr_s      = {ADDR_W{1'b0}};
          words_s    = {(ADDR_W+1){1'b0}};
          ovf_s      = 1'b0;
          end_pend_s = 1'b0;
        end else begin
          end_pend_s = load_end;
        end
        state_s = ST_HI;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    ready_s   = (state_s == ST_HI) || (state_s == ST_LO);
    loading_s = (state_s != ST_IDLE);
  end

  // Loader state and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      ptr_r      <= {ADDR_W{1'b0}};
      words_r    <= {(ADDR_W+1){1'b0}};
      ovf_r      <= 1'b0;
      hi_r       <= 8'h00;
      lo_r       <= 8'h00;
      end_pend_r <= 1'b0;
      ready_r    <= 1'b0;
      loading_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      words_r    <= words_s;
      ovf_r      <= ovf_s;
      hi_r       <= hi_s;
      lo_r       <= lo_s;
      end_pend_r <= end_pend_s;
      ready_r    <= ready_s;
      loading_r  <= loading_s;
    end
  end

  // Memory write port; the contents survive reset.
  always_ff @(posedge clk) begin
    if (dout_we_s) begin
      mem[ptr_r] <= {hi_r, lo_r};
    end
  end

  // Registered read port. A write to the same address in the same cycle returns the old word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_rd_r <= {DATA_W{1'b0}};
    end else begin
      data_rd_r <= mem[addrRd];
    end
  end

endmodule

// File: tb/tb_led_prog_ram.sv
// Directed, self-checking bench for led_prog_ram.
// Inputs change on the falling edge and outputs are sampled there too.
module tb_led_prog_ram;

  logic        clk;
  logic        rst;
  logic [7:0]  addrRd;
  logic [15:0] dataRd;
  logic        load_start;
  logic        load_end;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        loading;
  logic [8:0]  words_loaded;
  logic        overflow;

  int checks;
  int failures;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] exp;
  } rd_vec_t;

  rd_vec_t rd_basic [5];
  rd_vec_t rd_ovf   [5];

  led_prog_ram #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .addrRd(addrRd), .dataRd(dataRd),
    .load_start(load_start), .load_end(load_end),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .loading(loading), .words_loaded(words_loaded), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic pulse_end();
    load_end = 1'b1;
    tick();
    load_end = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    while (!byte_ready && waited < 8) begin
      tick();
      waited++;
    end
    if (!byte_ready) begin
      checks++;
      failures++;
      $display("FAIL byte_ready_timeout: got 0 expected 1");
    end else begin
      byte_in    = b;
      byte_valid = 1'b1;
      tick();
      byte_valid = 1'b0;
    end
  endtask

  task automatic read_word(input string name, input logic [7:0] a, input logic [15:0] exp);
    addrRd = a;
    tick();
    check(name, {16'h0000, dataRd}, {16'h0000, exp});
  endtask

  initial begin
    logic [7:0] idx;
    checks   = 0;
    failures = 0;

    rd_basic[0] = '{8'h00, 16'hAA03};
    rd_basic[1] = '{8'h01, 16'h5503};
    rd_basic[2] = '{8'h02, 16'h0000};
    rd_basic[3] = '{8'h00, 16'hAA03};
    rd_basic[4] = '{8'h01, 16'h5503};

    rd_ovf[0] = '{8'h00, 16'h00FF};
    rd_ovf[1] = '{8'h05, 16'h05FA};
    rd_ovf[2] = '{8'h80, 16'h807F};
    rd_ovf[3] = '{8'hFF, 16'hFF00};
    rd_ovf[4] = '{8'h01, 16'h01FE};

    rst        = 1'b0;
    addrRd     = 8'h05;
    load_start = 1'b0;
    load_end   = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;

    // Reset held for three cycles.
    repeat (3) tick();
    check("rst_dataRd",  {16'h0, dataRd}, 32'h0);
    check("rst_loading", {31'h0, loading}, 32'h0);
    check("rst_ready",   {31'h0, byte_ready}, 32'h0);
    check("rst_words",   {23'h0, words_loaded}, 32'h0);
    check("rst_ovf",     {31'h0, overflow}, 32'h0);
    rst = 1'b1;
    tick();
    check("idle_loading", {31'h0, loading}, 32'h0);
    check("idle_ready",   {31'h0, byte_ready}, 32'h0);

    // Basic load of three words.
    pulse_start();
    check("basic_loading_after_start", {31'h0, loading}, 32'h1);
    check("basic_ready_hi", {31'h0, byte_ready}, 32'h1);
    send_byte(8'hAA);
    send_byte(8'h03);
    check("basic_ready_in_wr", {31'h0, byte_ready}, 32'h0);
    check("basic_loading_in_wr", {31'h0, loading}, 32'h1);
    send_byte(8'h55);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h00);
    tick();
    check("basic_loading_before_end", {31'h0, loading}, 32'h1);
    pulse_end();
    check("basic_loading_after_end", {31'h0, loading}, 32'h0);
    check("basic_words", {23'h0, words_loaded}, 32'd3);
    for (int i = 0; i < 5; i++) begin
      read_word($sformatf("basic_rd%0d", i), rd_basic[i].addr, rd_basic[i].exp);
    end

    // Read latency: the new address is not visible before the next edge.
    addrRd = 8'h01;
    tick();
    addrRd = 8'h02;
    check("lat_hold", {16'h0, dataRd}, 32'h5503);
    tick();
    check("lat_next", {16'h0, dataRd}, 32'h0000);

    // Partial word: load_end while waiting for the low byte.
    pulse_start();
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    pulse_end();
    check("partial_loading", {31'h0, loading}, 32'h0);
    check("partial_words", {23'h0, words_loaded}, 32'd1);
    read_word("partial_m0", 8'h00, 16'h1234);
    read_word("partial_m1", 8'h01, 16'h5503);

    // Overflow: fill all 256 words, then one extra word.
    pulse_start();
    for (int w = 0; w < 256; w++) begin
      idx = w[7:0];
      send_byte(idx);
      send_byte(~idx);
    end
    send_byte(8'hDE);
    send_byte(8'hAD);
    tick();
    check("ovf_words", {23'h0, words_loaded}, 32'd256);
    check("ovf_flag", {31'h0, overflow}, 32'h1);
    pulse_end();
    check("ovf_flag_sticky", {31'h0, overflow}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      read_word($sformatf("ovf_rd%0d", i), rd_ovf[i].addr, rd_ovf[i].exp);
    end

    // A new load clears the counters; a restart in LO drops the high byte.
    pulse_start();
    check("restart_ovf_clear", {31'h0, overflow}, 32'h0);
    check("restart_words_clear", {23'h0, words_loaded}, 32'h0);
    send_byte(8'h77);
    pulse_start();
    send_byte(8'h11);
    send_byte(8'h22);
    // load_end arriving during WR: still loading for one HI cycle, then idle.
    pulse_end();
    check("wr_end_loading_hi", {31'h0, loading}, 32'h1);
    tick();
    check("wr_end_loading_idle", {31'h0, loading}, 32'h0);
    check("restart_words", {23'h0, words_loaded}, 32'd1);
    read_word("restart_m0", 8'h00, 16'h1122);

    // Simultaneous start and end: the start wins.
    load_start = 1'b1;
    load_end   = 1'b1;
    tick();
    load_start = 1'b0;
    load_end   = 1'b0;
    check("start_wins_loading", {31'h0, loading}, 32'h1);
    check("start_wins_words", {23'h0, words_loaded}, 32'h0);

    // Asynchronous reset in the middle of a load.
    addrRd = 8'h00;
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'hEF);
    check("pre_rst_words", {23'h0, words_loaded}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_loading", {31'h0, loading}, 32'h0);
    check("async_ready",   {31'h0, byte_ready}, 32'h0);
    check("async_words",   {23'h0, words_loaded}, 32'h0);
    check("async_dataRd",  {16'h0, dataRd}, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    check("post_rst_idle", {31'h0, loading}, 32'h0);
    read_word("post_rst_m0", 8'h00, 16'hABCD);
    read_word("post_rst_m1", 8'h01, 16'h01FE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
